// File: rtl/div_32_pkg.sv
// Shared constants and types for the 32-bit sequential restoring divider.
package div_pkg;

    localparam int DIV_W    = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 6;

    localparam logic [DIV_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

endpackage : div_pkg

// File: rtl/div_32_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_32_if;
    import div_pkg::*;

    logic             start;
    logic [DIV_W-1:0] a;
    logic [DIV_W-1:0] b;
    logic             done;
    logic [DIV_W-1:0] c;
    logic [DIV_W-1:0] d;

    modport master (output start, a, b, input  done, c, d);
    modport slave  (input  start, a, b, output done, c, d);

endinterface : div_32_if

// File: rtl/div_32_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it is non-negative.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W:0]   rem_i,
    input  logic             msb_i,
    input  logic [DIV_W-1:0] dvs_i,
    output logic [DIV_W:0]   rem_o,
    output logic             q_o
);

    // One extra bit above the shifted remainder carries the borrow of the trial subtract.
    logic [DIV_W+1:0] diff;

    always_comb begin
        diff  = {rem_i, msb_i} - {2'b00, dvs_i};
        q_o   = ~diff[DIV_W+1];
        rem_o = q_o ? diff[DIV_W:0] : {rem_i[DIV_W-1:0], msb_i};
    end

endmodule : div_step

// File: rtl/div_32.sv
// Unsigned 32-bit radix-2 restoring divider, one quotient bit per clock, with a
// one-cycle done pulse and results held until the next completion.
module div_32
    import div_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    div_32_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [DIV_W:0]   rem_q,   rem_d;
    logic [DIV_W-1:0] quo_q,   quo_d;
    logic [DIV_W-1:0] dvs_q,   dvs_d;
    logic [DIV_W-1:0] c_q,     c_d;
    logic [DIV_W-1:0] d_q,     d_d;
    logic             done_q,  done_d;

    logic [DIV_W:0]   step_rem;
    logic             step_q;

    div_step u_step (
        .rem_i (rem_q),
        .msb_i (quo_q[DIV_W-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        c_d     = c_q;
        d_d     = d_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0) begin
                        c_d    = DIV0_QUOT;
                        d_d    = bus.a;
                        done_d = 1'b1;
                    end else begin
                        quo_d   = bus.a;
                        dvs_d   = bus.b;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = {quo_q[DIV_W-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    c_d     = {quo_q[DIV_W-2:0], step_q};
                    d_d     = step_rem[DIV_W-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            c_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            c_q     <= c_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    assign bus.done = done_q;
    assign bus.c    = c_q;
    assign bus.d    = d_q;

endmodule : div_32

// File: tb/tb_div_32.sv
// Directed and random self-checking bench for div_32.
module tb_div_32;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_32_if bus ();

    div_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then wait (bounded) for done.
    // lat = edges from presenting start until done is seen, or -1 on timeout.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] cv, output logic [31:0] dv, output int lat);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        lat       = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        cv = bus.c;
        dv = bus.d;
    endtask

    logic [31:0] cv, dv, ra, rb;
    int          lat, first_done, gap;
    logic        bad;

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        tick(); tick();
        check("rst_done", bus.done, 0);
        check("rst_c", bus.c, 0);
        check("rst_d", bus.d, 0);
        rst = 1'b0;
        tick();

        // 43 / 7
        run_div(32'd43, 32'd7, cv, dv, lat);
        check("basic_lat", lat, 33);
        check("basic_c", cv, 6);
        check("basic_d", dv, 1);
        tick();
        check("basic_pulse_len", bus.done, 0);

        // Divide by zero
        run_div(32'd100, 32'd0, cv, dv, lat);
        check("div0_lat", lat, 1);
        check("div0_c", cv, 32'hFFFF_FFFF);
        check("div0_d", dv, 100);
        tick();
        check("div0_pulse_len", bus.done, 0);

        // Boundaries
        run_div(32'hFFFF_FFFF, 32'd1, cv, dv, lat);
        check("max_by_1_c", cv, 32'hFFFF_FFFF);
        check("max_by_1_d", dv, 0);
        tick();
        run_div(32'd5, 32'd9, cv, dv, lat);
        check("small_c", cv, 0);
        check("small_d", dv, 5);
        tick();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, cv, dv, lat);
        check("big_div_c", cv, 0);
        check("big_div_d", dv, 32'h8000_0000);
        tick();

        // Asynchronous reset in the middle of a division
        bus.start = 1'b1; bus.a = 32'd43; bus.b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_done", bus.done, 0);
        check("midrst_c", bus.c, 0);
        check("midrst_d", bus.d, 0);
        tick();
        rst = 1'b0;
        tick();
        run_div(32'd77, 32'd10, cv, dv, lat);
        check("post_rst_lat", lat, 33);
        check("post_rst_c", cv, 7);
        check("post_rst_d", dv, 7);
        tick();

        // Back-to-back with start held high; a changes during the second division
        bus.start = 1'b1; bus.a = 32'd43; bus.b = 32'd7;
        first_done = -1;
        gap        = -1;
        bad        = 1'b0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (i == 50) bus.a = 32'd1000;
            if (bus.done === 1'b1) begin
                if (first_done < 0) first_done = i;
                else begin
                    gap = i - first_done;
                    bus.start = 1'b0;
                    bus.a     = 32'd43;
                    break;
                end
            end
            if (first_done > 0 && (bus.c !== 32'd6 || bus.d !== 32'd1)) bad = 1'b1;
        end
        bus.start = 1'b0;
        check("b2b_first_lat", first_done, 33);
        check("b2b_period", gap, 33);
        check("b2b_hold_cd", bad, 0);
        check("b2b_c", bus.c, 6);
        check("b2b_d", bus.d, 1);
        tick();
        check("b2b_pulse_len", bus.done, 0);
        tick();

        // Random regression
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom();
            if (rb == 0) rb = 32'd1;
            run_div(ra, rb, cv, dv, lat);
            check("rand_identity", {32'd0, cv} * {32'd0, rb} + {32'd0, dv}, {32'd0, ra});
            check("rand_rem_lt_div", (dv < rb), 1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_div_32
